// File: rtl/key_debounce_arb.sv
// ---------------------------------------------------------------------------
// key_debounce_arb
//
// Debounces N_KEYS raw active-low push buttons using a single shared stable
// time counter. A round-robin arbiter hands the counter to one key at a time.
// A key whose synchronized level stays at the captured target for
// DEBOUNCE_CYCLES cycles is committed. The commit updates its debounced
// level, raises a one-cycle press or release pulse, and toggles its LED on a
// press.
//
// Ports:
//   sys_clk     - single rising-edge clock
//   rst         - asynchronous active-high reset
//   key         - raw asynchronous keys, 0 = pressed
//   key_state   - debounced key level, 1 = released
//   key_press   - one-cycle pulse on a debounced press
//   key_release - one-cycle pulse on a debounced release
//   led         - bit i toggles on each debounced press of key i
//   busy        - high while the shared counter is allocated to a key
// ---------------------------------------------------------------------------
module key_debounce_arb #(
   parameter int N_KEYS          = 4,
   parameter int DEBOUNCE_CYCLES = 4000000,
   parameter int CNT_W           = 22
) (
   input  logic              sys_clk,
   input  logic              rst,
   input  logic [N_KEYS-1:0] key,
   output logic [N_KEYS-1:0] key_state,
   output logic [N_KEYS-1:0] key_press,
   output logic [N_KEYS-1:0] key_release,
   output logic [N_KEYS-1:0] led,
   output logic              busy
);

   localparam int GW = $clog2(N_KEYS);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_COUNT  = 2'd1;
   localparam logic [1:0] S_COMMIT = 2'd2;

   logic [N_KEYS-1:0] sync_meta;
   logic [N_KEYS-1:0] sync;
   logic [N_KEYS-1:0] pending;
   logic [1:0]        state;
   logic [CNT_W-1:0]  cnt;
   logic [GW-1:0]     grant;
   logic [GW-1:0]     last_grant;
   logic [GW-1:0]     pick;
   logic              target;
   logic              found;
   logic [GW:0]       rr_sum;

   // Two-flop synchronizer for the raw keys. Both stages reset to the
   // released level so that a reset never looks like a press.
   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         sync_meta <= '1;
         sync      <= '1;
      end else begin
         sync_meta <= key;
         sync      <= sync_meta;
      end
   end

   // A key needs attention whenever its synchronized level disagrees with
   // the debounced level. A bounce back to the old level clears it again
   // before it is ever granted.
   assign pending = sync ^ key_state;

   assign busy = (state != S_IDLE);

   // Round-robin pick: scan from last_grant+1 and wrap at N_KEYS. The sum
   // never exceeds 2*N_KEYS-1, so a single conditional subtract performs the
   // wrap.
   always_comb begin
      found  = 1'b0;
      pick   = '0;
      rr_sum = '0;
      for (int k = 1; k <= N_KEYS; k++) begin
         rr_sum = {1'b0, last_grant} + (GW+1)'(k);
         if (rr_sum >= (GW+1)'(N_KEYS)) begin
            rr_sum = rr_sum - (GW+1)'(N_KEYS);
         end
         if (!found && pending[rr_sum[GW-1:0]]) begin
            found = 1'b1;
            pick  = rr_sum[GW-1:0];
         end
      end
   end

   // Arbiter and debounce FSM. IDLE grants the next pending key and captures
   // its target level. COUNT requires that level to hold for DEBOUNCE_CYCLES
   // cycles and abandons the key on any deviation. COMMIT publishes the new
   // level and the pulse, which become visible in the following cycle. The
   // pulse vectors default to zero every cycle, so a pulse lasts one cycle,
   // and only one key can commit at a time.
   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         cnt         <= '0;
         grant       <= '0;
         last_grant  <= GW'(N_KEYS - 1);
         target      <= 1'b1;
         key_state   <= '1;
         key_press   <= '0;
         key_release <= '0;
         led         <= '0;
      end else begin
         key_press   <= '0;
         key_release <= '0;
         case (state)
            S_IDLE: begin
               if (found) begin
                  grant  <= pick;
                  target <= sync[pick];
                  cnt    <= '0;
                  state  <= S_COUNT;
               end
            end
            S_COUNT: begin
               if (sync[grant] != target) begin
                  last_grant <= grant;
                  state      <= S_IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
                  if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                     state <= S_COMMIT;
                  end
               end
            end
            S_COMMIT: begin
               key_state[grant] <= target;
               if (!target) begin
                  key_press[grant] <= 1'b1;
                  led[grant]       <= ~led[grant];
               end else begin
                  key_release[grant] <= 1'b1;
               end
               last_grant <= grant;
               state      <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_key_debounce_arb.sv
// ---------------------------------------------------------------------------
// tb_key_debounce_arb
//
// Self-checking bench for key_debounce_arb with N_KEYS = 4 and
// DEBOUNCE_CYCLES = 16. A cycle-level reference model predicts every output.
// The model tracks the time each granted key has been stable, not the RTL's
// counter. It is compared on every falling edge. Directed table rows and
// hand-written timing sequences check the documented latencies.
// ---------------------------------------------------------------------------
module tb_key_debounce_arb;

   localparam int N = 4;
   localparam int D = 16;

   logic         sys_clk = 1'b0;
   logic         rst;
   logic [N-1:0] key;
   logic [N-1:0] key_state;
   logic [N-1:0] key_press;
   logic [N-1:0] key_release;
   logic [N-1:0] led;
   logic         busy;

   int checks = 0;
   int errors = 0;
   logic mon_en = 1'b0;

   key_debounce_arb #(
      .N_KEYS(N),
      .DEBOUNCE_CYCLES(D),
      .CNT_W(5)
   ) dut (
      .sys_clk(sys_clk),
      .rst(rst),
      .key(key),
      .key_state(key_state),
      .key_press(key_press),
      .key_release(key_release),
      .led(led),
      .busy(busy)
   );

   // 10 ns clock period.
   always #5 sys_clk = ~sys_clk;

   // Compares one value against its expectation and counts the outcome.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Advances to just after the next rising edge.
   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   // Reference model. The raw keys reach the arbiter through a two-sample
   // delay line. A granted key must stay at its target for D consecutive
   // cycles and then takes one cycle to publish. The model keeps time as an
   // age in cycles and a phase.
   logic [N-1:0] dly[$];
   logic [N-1:0] m_sync, m_state, m_led, m_press, m_rel, m_pend;
   int           m_phase;
   int           m_key, m_last, m_age;
   logic         m_target;

   always @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         dly      = {};
         dly.push_back(4'hF);
         m_sync   = 4'hF;
         m_state  = 4'hF;
         m_led    = 4'h0;
         m_press  = 4'h0;
         m_rel    = 4'h0;
         m_phase  = 0;
         m_key    = 0;
         m_last   = N - 1;
         m_age    = 0;
         m_target = 1'b1;
      end else begin
         m_press = 4'h0;
         m_rel   = 4'h0;
         if (m_phase == 0) begin
            m_pend = m_sync ^ m_state;
            if (m_pend != 4'h0) begin
               for (int k = 1; k <= N; k++) begin
                  if (m_phase == 0 && m_pend[(m_last + k) % N]) begin
                     m_key    = (m_last + k) % N;
                     m_target = m_sync[m_key];
                     m_age    = 0;
                     m_phase  = 1;
                  end
               end
            end
         end else if (m_phase == 1) begin
            if (m_sync[m_key] != m_target) begin
               m_last  = m_key;
               m_phase = 0;
            end else begin
               m_age++;
               if (m_age == D) m_phase = 2;
            end
         end else begin
            m_state[m_key] = m_target;
            if (!m_target) begin
               m_press[m_key] = 1'b1;
               m_led[m_key]   = ~m_led[m_key];
            end else begin
               m_rel[m_key] = 1'b1;
            end
            m_last  = m_key;
            m_phase = 0;
         end
         dly.push_back(key);
         m_sync = dly.pop_front();
      end
   end

   // Continuous comparison against the model away from the active edge.
   always @(negedge sys_clk) begin
      if (mon_en) begin
         checkOutput("model key_state", 32'(key_state), 32'(m_state));
         checkOutput("model key_press", 32'(key_press), 32'(m_press));
         checkOutput("model key_release", 32'(key_release), 32'(m_rel));
         checkOutput("model led", 32'(led), 32'(m_led));
         checkOutput("model busy", 32'(busy), 32'(m_phase != 0));
      end
   end

   typedef struct {
      logic [N-1:0] key;
      int           hold;
      logic [N-1:0] exp_state;
      logic [N-1:0] exp_led;
      int           exp_press;
      int           exp_rel;
      logic         exp_busy;
   } vec_t;

   vec_t vecs[7];

   // Drives one table row for its hold time, counts pulses and checks the
   // settled outputs.
   task automatic applyStimulus(input vec_t v, input int idx);
      int np;
      int nr;
      np  = 0;
      nr  = 0;
      key = v.key;
      for (int t = 0; t < v.hold; t++) begin
         tick();
         np += $countones(key_press);
         nr += $countones(key_release);
      end
      checkOutput($sformatf("row%0d key_state", idx), 32'(key_state), 32'(v.exp_state));
      checkOutput($sformatf("row%0d led", idx), 32'(led), 32'(v.exp_led));
      checkOutput($sformatf("row%0d presses", idx), 32'(np), 32'(v.exp_press));
      checkOutput($sformatf("row%0d releases", idx), 32'(nr), 32'(v.exp_rel));
      checkOutput($sformatf("row%0d busy", idx), 32'(busy), 32'(v.exp_busy));
   endtask

   // Applies a reset of a few cycles with all keys released.
   task automatic doReset();
      rst = 1'b1;
      key = 4'hF;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      int tp;
      int t2;
      int t3;
      int tr;
      logic [N-1:0] kv;

      // Clean press, bounce, simultaneous press, and releases.
      vecs[0] = '{4'hF,  5, 4'hF, 4'h0, 0, 0, 1'b0};
      vecs[1] = '{4'hE, 25, 4'hE, 4'h1, 1, 0, 1'b0};
      vecs[2] = '{4'hC,  5, 4'hE, 4'h1, 0, 0, 1'b1};
      vecs[3] = '{4'hE, 15, 4'hE, 4'h1, 0, 0, 1'b0};
      vecs[4] = '{4'h2, 45, 4'h2, 4'hD, 2, 0, 1'b0};
      vecs[5] = '{4'h3, 25, 4'h3, 4'hD, 0, 1, 1'b0};
      vecs[6] = '{4'hF, 50, 4'hF, 4'hD, 0, 2, 1'b0};

      // Check the outputs while reset is held.
      rst = 1'b1;
      key = 4'hF;
      tick();
      tick();
      tick();
      checkOutput("reset key_state", 32'(key_state), 32'hF);
      checkOutput("reset led", 32'(led), 32'h0);
      checkOutput("reset busy", 32'(busy), 32'h0);
      checkOutput("reset pulses", 32'(key_press | key_release), 32'h0);
      mon_en = 1'b1;
      rst    = 1'b0;

      for (int i = 0; i < 7; i++) applyStimulus(vecs[i], i);

      // Exact press latency of D+4 cycles from the raw edge.
      doReset();
      for (int t = 0; t < 5; t++) tick();
      key = 4'hE;
      for (int t = 1; t <= 21; t++) begin
         tick();
         if (t == 19) checkOutput("press0 at +19", 32'(key_press), 32'h0);
         if (t == 20) checkOutput("press0 at +20", 32'(key_press), 32'h1);
         if (t == 21) checkOutput("press0 at +21", 32'(key_press), 32'h0);
      end
      checkOutput("press0 key_state", 32'(key_state), 32'hE);
      checkOutput("press0 led", 32'(led), 32'h1);

      // Simultaneous press of keys 2 and 3: the second pulse follows D+2
      // cycles after the first.
      key = 4'h2;
      t2  = -1;
      t3  = -1;
      for (int t = 1; t <= 45; t++) begin
         tick();
         if (key_press == 4'b0100 && t2 < 0) t2 = t;
         if (key_press == 4'b1000 && t3 < 0) t3 = t;
      end
      checkOutput("simul press2 cycle", 32'(t2), 32'd20);
      checkOutput("simul press3 cycle", 32'(t3), 32'd38);
      checkOutput("simul led", 32'(led), 32'hD);

      // Releasing key 0 pulses key_release[0] and leaves the LEDs unchanged.
      key = 4'h3;
      tr  = -1;
      for (int t = 1; t <= 25; t++) begin
         tick();
         if (key_release == 4'b0001 && tr < 0) tr = t;
      end
      checkOutput("release0 cycle", 32'(tr), 32'd20);
      checkOutput("release0 led", 32'(led), 32'hD);
      checkOutput("release0 key_state", 32'(key_state[0]), 32'h1);

      // Reset asserted at cnt = 8 discards the debounce. The held key then
      // restarts from scratch after reset is released.
      doReset();
      for (int t = 0; t < 5; t++) tick();
      key = 4'hE;
      for (int t = 0; t < 11; t++) tick();
      checkOutput("pre-reset busy", 32'(busy), 32'h1);
      rst = 1'b1;
      tick();
      tick();
      checkOutput("midcount key_state", 32'(key_state), 32'hF);
      checkOutput("midcount busy", 32'(busy), 32'h0);
      checkOutput("midcount press", 32'(key_press), 32'h0);
      rst = 1'b0;
      tp  = -1;
      for (int t = 1; t <= 25; t++) begin
         tick();
         if (key_press == 4'b0001 && tp < 0) tp = t;
      end
      checkOutput("post-reset press cycle", 32'(tp), 32'd20);

      // Random key activity with bounce bursts and one reset, checked
      // entirely by the model.
      kv = key;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 99) < 4) kv[$urandom_range(0, N - 1)] ^= 1'b1;
         if ((i % 500) < 40 && $urandom_range(0, 99) < 30) kv[$urandom_range(0, N - 1)] ^= 1'b1;
         key = kv;
         if (i == 2500) rst = 1'b1;
         if (i == 2502) rst = 1'b0;
         tick();
      end
      key = 4'hF;
      for (int t = 0; t < 120; t++) tick();
      checkOutput("final key_state", 32'(key_state), 32'hF);
      checkOutput("final busy", 32'(busy), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
